// File: rtl/rv_plic_claim_pkg.sv
// Shared types and defaults for the PLIC claim agent.
//   state_e        agent FSM state encoding
//   NumSrcDefault  default number of interrupt sources (ID 0 means "no interrupt")
//   SrcWDefault    default ID width
//   decode_id()    ID to one-hot source vector at the default width; IDs 0 and
//                  >= NumSrcDefault decode to all-zero
package rv_plic_claim_pkg;

  localparam int unsigned NumSrcDefault = 55;
  localparam int unsigned SrcWDefault   = $clog2(NumSrcDefault);

  typedef enum logic [2:0] {
    StIdle,
    StClaim,
    StDispatch,
    StWait,
    StComplete,
    StHoldoff
  } state_e;

  function automatic logic [NumSrcDefault-1:0] decode_id(input logic [SrcWDefault-1:0] id);
    logic [NumSrcDefault-1:0] vec;
    vec = '0;
    for (int unsigned i = 1; i < NumSrcDefault; i++) begin
      if (32'(id) == i) vec[i] = 1'b1;
    end
    return vec;
  endfunction

endpackage

// File: rtl/rv_plic_claim_timer.sv
// Handler watchdog counter for the PLIC claim agent.
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   clear_i   restart the count at 0 on the next edge
//   enable_i  count this cycle
//   expire_o  count has reached TimeoutCycles-1 while enabled
module rv_plic_claim_timer #(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    expire_o = enable_i && (cnt_q == CntLast);
    cnt_d    = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rv_plic_claim_agent.sv
// Target-side agent for one PLIC target: claims the PLIC's highest-priority ID,
// hands it to a local handler over valid/ready, and issues the complete pulse
// when the handler reports done.
// Optional feature macro: RV_PLIC_CLAIM_TIMEOUT_EN enables a handler watchdog
// that forces completion after TimeoutCycles in WAIT.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   enable_i            0 holds the agent in IDLE (in-flight sequence finishes)
//   irq_i, irq_id_i     PLIC target request and ID
//   claim_o, complete_o one-hot single-cycle pulses back to the PLIC
//   disp_valid_o/disp_id_o/disp_ready_i  dispatch handshake to the handler
//   done_i              handler finished (single-cycle pulse)
//   busy_o              agent not in IDLE
//   spurious_cnt_o      saturating count of claims with an invalid ID
//   timeout_o           watchdog forced this completion (pulse with complete_o)
//   timeout_err_o       sticky watchdog flag, cleared by reset
module rv_plic_claim_agent
  import rv_plic_claim_pkg::*;
#(
  parameter int unsigned NumSrc        = NumSrcDefault,
  parameter int unsigned SrcW          = SrcWDefault,
  parameter int unsigned CntW          = 8,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              irq_i,
  input  logic [SrcW-1:0]   irq_id_i,
  output logic [NumSrc-1:0] claim_o,
  output logic [NumSrc-1:0] complete_o,
  output logic              disp_valid_o,
  output logic [SrcW-1:0]   disp_id_o,
  input  logic              disp_ready_i,
  input  logic              done_i,
  output logic              busy_o,
  output logic [CntW-1:0]   spurious_cnt_o,
  output logic              timeout_o,
  output logic              timeout_err_o
);

  state_e            state_d, state_q;
  logic [SrcW-1:0]   id_d, id_q;
  logic [CntW-1:0]   spur_d, spur_q;
  logic              id_ok;
  logic [NumSrc-1:0] id_onehot;

  // ID 0 and out-of-range IDs are both treated as spurious.
  assign id_ok = (id_q != '0) && (32'(id_q) < NumSrc);

  always_comb begin
    id_onehot = '0;
    if (id_ok) id_onehot[id_q] = 1'b1;
  end

`ifdef RV_PLIC_CLAIM_TIMEOUT_EN
  logic timer_clear, timer_en, timer_expire;
  logic timed_out_d, timed_out_q;
  logic tout_err_d, tout_err_q;

  rv_plic_claim_timer #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (timer_clear),
    .enable_i(timer_en),
    .expire_o(timer_expire)
  );
`endif

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    spur_d       = spur_q;
    claim_o      = '0;
    complete_o   = '0;
    disp_valid_o = 1'b0;
    disp_id_o    = '0;
`ifdef RV_PLIC_CLAIM_TIMEOUT_EN
    timer_clear  = 1'b0;
    timer_en     = 1'b0;
    timed_out_d  = timed_out_q;
    tout_err_d   = tout_err_q;
    timeout_o    = 1'b0;
`else
    timeout_o    = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (enable_i && irq_i) begin
          id_d    = irq_id_i;
          state_d = StClaim;
        end
      end
      StClaim: begin
        if (id_ok) begin
          claim_o = id_onehot;
          state_d = StDispatch;
        end else begin
          if (spur_q != '1) spur_d = spur_q + 1'b1;
          state_d = StHoldoff;
        end
      end
      StDispatch: begin
        disp_valid_o = 1'b1;
        disp_id_o    = id_q;
        if (disp_ready_i) begin
          state_d = StWait;
`ifdef RV_PLIC_CLAIM_TIMEOUT_EN
          timer_clear = 1'b1;
`endif
        end
      end
      StWait: begin
`ifdef RV_PLIC_CLAIM_TIMEOUT_EN
        timer_en = 1'b1;
        // A real done on the expiry cycle wins over the watchdog.
        if (done_i) begin
          timed_out_d = 1'b0;
          state_d     = StComplete;
        end else if (timer_expire) begin
          timed_out_d = 1'b1;
          tout_err_d  = 1'b1;
          state_d     = StComplete;
        end
`else
        if (done_i) state_d = StComplete;
`endif
      end
      StComplete: begin
        complete_o = id_onehot;
`ifdef RV_PLIC_CLAIM_TIMEOUT_EN
        timeout_o   = timed_out_q;
        timed_out_d = 1'b0;
`endif
        state_d = StHoldoff;
      end
      // One dead cycle so the PLIC's stale irq/ID is not claimed again.
      StHoldoff: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign busy_o         = (state_q != StIdle);
  assign spurious_cnt_o = spur_q;

`ifdef RV_PLIC_CLAIM_TIMEOUT_EN
  assign timeout_err_o = tout_err_q;
`else
  assign timeout_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      id_q    <= '0;
      spur_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      spur_q  <= spur_d;
    end
  end

`ifdef RV_PLIC_CLAIM_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timed_out_q <= 1'b0;
      tout_err_q  <= 1'b0;
    end else begin
      timed_out_q <= timed_out_d;
      tout_err_q  <= tout_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_rv_plic_claim_agent.sv
module tb_rv_plic_claim_agent;

  localparam int unsigned NumSrc = 55;
  localparam int unsigned SrcW   = 6;
  localparam int unsigned CntW   = 8;

  localparam logic [NumSrc-1:0] Bit3 = 55'd1 << 3;
  localparam logic [NumSrc-1:0] Bit5 = 55'd1 << 5;
  localparam logic [NumSrc-1:0] Bit7 = 55'd1 << 7;
  localparam logic [NumSrc-1:0] Bit9 = 55'd1 << 9;
  localparam logic [NumSrc-1:0] Zero = '0;

  logic              clk = 1'b0;
  logic              rst_i, enable_i, irq_i, disp_ready_i, done_i;
  logic [SrcW-1:0]   irq_id_i;
  logic [NumSrc-1:0] claim_o, complete_o;
  logic              disp_valid_o, busy_o, timeout_o, timeout_err_o;
  logic [SrcW-1:0]   disp_id_o;
  logic [CntW-1:0]   spurious_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_plic_claim_agent #(
    .NumSrc       (NumSrc),
    .SrcW         (SrcW),
    .CntW         (CntW),
    .TimeoutCycles(16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .irq_i         (irq_i),
    .irq_id_i      (irq_id_i),
    .claim_o       (claim_o),
    .complete_o    (complete_o),
    .disp_valid_o  (disp_valid_o),
    .disp_id_o     (disp_id_o),
    .disp_ready_i  (disp_ready_i),
    .done_i        (done_i),
    .busy_o        (busy_o),
    .spurious_cnt_o(spurious_cnt_o),
    .timeout_o     (timeout_o),
    .timeout_err_o (timeout_err_o)
  );

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; enable_i = 1'b1; irq_i = 1'b0; irq_id_i = '0;
    disp_ready_i = 1'b0; done_i = 1'b0;
    tick(); tick();
    checks++;
    if ({claim_o, complete_o} !== {Zero, Zero}) begin
      errors++; $display("FAIL reset_pulses: got %h/%h required 0/0", claim_o, complete_o);
    end
    checks++;
    if ({disp_valid_o, disp_id_o, busy_o, spurious_cnt_o, timeout_o, timeout_err_o} !== '0) begin
      errors++;
      $display("FAIL reset_outs: valid=%b id=%0d busy=%b cnt=%0d to=%b err=%b required all 0",
               disp_valid_o, disp_id_o, busy_o, spurious_cnt_o, timeout_o, timeout_err_o);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    disp_ready_i = 1'b1; irq_i = 1'b1; irq_id_i = 6'd5;
    tick();  // CLAIM
    irq_i = 1'b0;
    checks++;
    if (claim_o !== Bit5 || !busy_o) begin
      errors++; $display("FAIL basic_claim: got %h busy=%b required %h busy=1", claim_o, busy_o, Bit5);
    end
    tick();  // DISPATCH
    checks++;
    if (!disp_valid_o || disp_id_o !== 6'd5 || claim_o !== Zero) begin
      errors++; $display("FAIL basic_disp: valid=%b id=%0d required 1/5", disp_valid_o, disp_id_o);
    end
    tick();  // WAIT, accept edge passed
    tick(); tick(); tick();
    checks++;
    if (disp_valid_o || complete_o !== Zero || !busy_o) begin
      errors++; $display("FAIL basic_wait: valid=%b complete=%h required 0/0", disp_valid_o, complete_o);
    end
    done_i = 1'b1;
    tick();  // COMPLETE
    done_i = 1'b0;
    checks++;
    if (complete_o !== Bit5 || claim_o !== Zero || timeout_o) begin
      errors++; $display("FAIL basic_complete: got %h required %h", complete_o, Bit5);
    end
    tick();  // HOLDOFF
    checks++;
    if (complete_o !== Zero || !busy_o) begin
      errors++; $display("FAIL basic_holdoff: complete=%h busy=%b required 0/1", complete_o, busy_o);
    end
    tick();  // IDLE
    checks++;
    if (busy_o) begin
      errors++; $display("FAIL basic_idle: busy=%b required 0", busy_o);
    end
  endtask

  task automatic spurious_once(input logic [SrcW-1:0] id);
    irq_i = 1'b1; irq_id_i = id;
    tick();
    irq_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_spurious();
    irq_i = 1'b1; irq_id_i = 6'd0;
    tick();  // CLAIM with ID 0
    irq_i = 1'b0;
    checks++;
    if (claim_o !== Zero || !busy_o) begin
      errors++; $display("FAIL spur_claim0: got %h required 0", claim_o);
    end
    tick();  // HOLDOFF
    checks++;
    if (spurious_cnt_o !== 8'd1 || complete_o !== Zero || disp_valid_o) begin
      errors++; $display("FAIL spur_cnt1: got %0d required 1", spurious_cnt_o);
    end
    tick();
    irq_i = 1'b1; irq_id_i = 6'd60;
    tick();  // CLAIM with out-of-range ID
    irq_i = 1'b0;
    checks++;
    if (claim_o !== Zero) begin
      errors++; $display("FAIL spur_claim60: got %h required 0", claim_o);
    end
    tick(); tick();
    checks++;
    if (spurious_cnt_o !== 8'd2 || busy_o) begin
      errors++; $display("FAIL spur_cnt2: got %0d busy=%b required 2/0", spurious_cnt_o, busy_o);
    end
    for (int i = 0; i < 253; i++) spurious_once(6'd0);
    checks++;
    if (spurious_cnt_o !== 8'd255) begin
      errors++; $display("FAIL spur_cnt255: got %0d required 255", spurious_cnt_o);
    end
    spurious_once(6'd0);
    checks++;
    if (spurious_cnt_o !== 8'd255) begin
      errors++; $display("FAIL spur_saturate: got %0d required 255", spurious_cnt_o);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    disp_ready_i = 1'b0; irq_i = 1'b1; irq_id_i = 6'd9;
    tick();  // CLAIM
    irq_i = 1'b0;
    tick();  // DISPATCH
    for (int i = 0; i < 10; i++) begin
      if (!disp_valid_o || disp_id_o !== 6'd9) bad++;
      tick();
    end
    // Accept cycle; a done pulse here must be ignored.
    if (!disp_valid_o || disp_id_o !== 6'd9) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_hold: %0d of 11 cycles lost valid/id 9, required 0", bad);
    end
    disp_ready_i = 1'b1; done_i = 1'b1;
    tick();  // WAIT
    done_i = 1'b0;
    checks++;
    if (disp_valid_o || !busy_o) begin
      errors++; $display("FAIL bp_wait: valid=%b busy=%b required 0/1", disp_valid_o, busy_o);
    end
    tick();
    checks++;
    if (complete_o !== Zero) begin
      errors++; $display("FAIL bp_done_accept_ignored: complete=%h required 0", complete_o);
    end
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    checks++;
    if (complete_o !== Bit9) begin
      errors++; $display("FAIL bp_complete: got %h required %h", complete_o, Bit9);
    end
    tick(); tick();
  endtask

  task automatic test_holdoff();
    int bad = 0;
    disp_ready_i = 1'b1; irq_i = 1'b1; irq_id_i = 6'd5;
    tick(); tick(); tick();  // CLAIM, DISPATCH, WAIT
    done_i = 1'b1;
    tick();  // COMPLETE
    done_i = 1'b0;
    if (complete_o !== Bit5) bad++;
    tick();  // HOLDOFF
    if (claim_o !== Zero) bad++;
    tick();  // IDLE
    if (claim_o !== Zero) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL holdoff_no_reclaim: %0d bad cycles required 0", bad);
    end
    tick();  // complete + 3
    checks++;
    if (claim_o !== Bit5) begin
      errors++; $display("FAIL holdoff_next_claim: got %h required %h", claim_o, Bit5);
    end
    // Drop enable mid-flow: the sequence finishes, nothing new is claimed.
    enable_i = 1'b0;
    tick(); tick();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    checks++;
    if (complete_o !== Bit5) begin
      errors++; $display("FAIL enable_finish: got %h required %h", complete_o, Bit5);
    end
    tick(); tick(); tick(); tick();
    checks++;
    if (busy_o || claim_o !== Zero) begin
      errors++; $display("FAIL enable_hold_idle: busy=%b claim=%h required 0/0", busy_o, claim_o);
    end
    irq_i = 1'b0; enable_i = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    disp_ready_i = 1'b1; irq_i = 1'b1; irq_id_i = 6'd7;
    tick();
    irq_i = 1'b0;
    checks++;
    if (claim_o !== Bit7) begin
      errors++; $display("FAIL rst_mid_claim: got %h required %h", claim_o, Bit7);
    end
    tick(); tick();  // WAIT
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++;
    if (busy_o || claim_o !== Zero || complete_o !== Zero || disp_valid_o || disp_id_o !== '0
        || spurious_cnt_o !== '0) begin
      errors++;
      $display("FAIL rst_mid_idle: busy=%b cmp=%h valid=%b id=%0d cnt=%0d required all 0",
               busy_o, complete_o, disp_valid_o, disp_id_o, spurious_cnt_o);
    end
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    checks++;
    if (complete_o !== Zero || busy_o) begin
      errors++; $display("FAIL rst_mid_no_complete: got %h busy=%b required 0/0", complete_o, busy_o);
    end
    tick();
  endtask

  task automatic test_timeout();
    int bad = 0;
    disp_ready_i = 1'b1; irq_i = 1'b1; irq_id_i = 6'd3;
    tick();
    irq_i = 1'b0;
    tick(); tick();  // first WAIT cycle
`ifdef RV_PLIC_CLAIM_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      if (complete_o !== Zero || timeout_o || timeout_err_o) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL to_early: %0d early cycles required 0", bad);
    end
    checks++;
    if (complete_o !== Bit3 || !timeout_o || !timeout_err_o) begin
      errors++; $display("FAIL to_fire: cmp=%h to=%b err=%b required %h/1/1",
                         complete_o, timeout_o, timeout_err_o, Bit3);
    end
    tick(); tick();
    checks++;
    if (timeout_o || !timeout_err_o || busy_o) begin
      errors++; $display("FAIL to_sticky: to=%b err=%b busy=%b required 0/1/0",
                         timeout_o, timeout_err_o, busy_o);
    end
`else
    for (int i = 0; i < 40; i++) begin
      if (complete_o !== Zero || timeout_o || timeout_err_o || !busy_o) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL to_off_wait: %0d bad cycles required 0", bad);
    end
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    checks++;
    if (complete_o !== Bit3 || timeout_o) begin
      errors++; $display("FAIL to_off_complete: got %h to=%b required %h/0", complete_o, timeout_o, Bit3);
    end
    tick(); tick();
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_spurious();
    test_backpressure();
    test_holdoff();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
